// File: rtl/idaub6_pkg.sv
// Shared constants and types for the idaub6 6-tap inverse wavelet synthesis block.
package idaub6_pkg;

    localparam int unsigned ACC_OFS = 6;

    localparam int H_TAP [6] = '{5, 13, 7, -2, -1, 1};
    localparam int G_TAP [6] = '{1, 1, -2, -7, 13, -5};

    typedef enum logic [1:0] {
        S_EMPTY,
        S_EVEN,
        S_ODD
    } state_t;

endpackage

// File: rtl/idaub6_mac.sv
// Combinational 6-term shift-add dot product; PHASE=0 uses even taps, PHASE=1 odd taps.
module idaub6_mac
    import idaub6_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PHASE      = 0
) (
    input  logic signed [DATA_WIDTH-1:0]         i_a0,
    input  logic signed [DATA_WIDTH-1:0]         i_a1,
    input  logic signed [DATA_WIDTH-1:0]         i_a2,
    input  logic signed [DATA_WIDTH-1:0]         i_d0,
    input  logic signed [DATA_WIDTH-1:0]         i_d1,
    input  logic signed [DATA_WIDTH-1:0]         i_d2,
    output logic signed [DATA_WIDTH+ACC_OFS-1:0] o_sum
);

    localparam int unsigned ACC_W = DATA_WIDTH + ACC_OFS;

    // Constant taps fold each call into a handful of shifted adds.
    function automatic logic signed [ACC_W-1:0] tap_mul(
        input logic signed [DATA_WIDTH-1:0] x,
        input int                           tap
    );
        logic signed [ACC_W-1:0] xe;
        logic signed [ACC_W-1:0] acc;
        int unsigned             mag;
        xe  = ACC_W'(x);
        acc = '0;
        mag = (tap < 0) ? unsigned'(-tap) : unsigned'(tap);
        for (int unsigned b = 0; b < 32; b++) begin
            if (mag[b]) acc = acc + (xe <<< b);
        end
        return (tap < 0) ? -acc : acc;
    endfunction

    always_comb begin
        o_sum = tap_mul(i_a0, H_TAP[PHASE])     + tap_mul(i_a1, H_TAP[PHASE+2])
              + tap_mul(i_a2, H_TAP[PHASE+4])   + tap_mul(i_d0, G_TAP[PHASE])
              + tap_mul(i_d1, G_TAP[PHASE+2])   + tap_mul(i_d2, G_TAP[PHASE+4]);
    end

endmodule

// File: rtl/idaub6_synth.sv
// Inverse 6-tap wavelet synthesis: one (a,d) pair in, even then odd sample out.
// Define IDAUB6_SAT_EN to clamp outputs instead of wrapping.
module idaub6_synth
    import idaub6_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SHIFT      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic signed [DATA_WIDTH-1:0] in_a,
    input  logic signed [DATA_WIDTH-1:0] in_d,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] out_x,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_warm
);

    localparam int unsigned ACC_W = DATA_WIDTH + ACC_OFS;

    state_t                  r_state;
    state_t                  w_state_nx;
    logic signed [DATA_WIDTH-1:0] r_a1, r_a2, r_d1, r_d2;
    logic signed [ACC_W-1:0] r_even, r_odd;
    logic signed [ACC_W-1:0] w_even, w_odd, w_sel;
    logic [1:0]              r_warm;
    logic                    w_in_acc, w_out_acc;

    idaub6_mac #(.DATA_WIDTH(DATA_WIDTH), .PHASE(0)) u_mac_even (
        .i_a0(in_a), .i_a1(r_a1), .i_a2(r_a2),
        .i_d0(in_d), .i_d1(r_d1), .i_d2(r_d2),
        .o_sum(w_even)
    );

    idaub6_mac #(.DATA_WIDTH(DATA_WIDTH), .PHASE(1)) u_mac_odd (
        .i_a0(in_a), .i_a1(r_a1), .i_a2(r_a2),
        .i_d0(in_d), .i_d1(r_d1), .i_d2(r_d2),
        .o_sum(w_odd)
    );

    assign in_ready  = !clear && ((r_state == S_EMPTY) || ((r_state == S_ODD) && out_ready));
    assign out_valid = (r_state == S_EVEN) || (r_state == S_ODD);
    assign w_in_acc  = in_valid && in_ready;
    assign w_out_acc = out_valid && out_ready;
    assign out_warm  = (r_warm == 2'd3);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_EMPTY: if (w_in_acc)  w_state_nx = S_EVEN;
            S_EVEN:  if (w_out_acc) w_state_nx = S_ODD;
            S_ODD:   if (w_out_acc) w_state_nx = w_in_acc ? S_EVEN : S_EMPTY;
            default: w_state_nx = S_EMPTY;
        endcase
        if (clear) w_state_nx = S_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_EMPTY;
        else        r_state <= w_state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a1 <= '0; r_a2 <= '0; r_d1 <= '0; r_d2 <= '0;
            r_even <= '0; r_odd <= '0; r_warm <= '0;
        end else if (clear) begin
            r_a1 <= '0; r_a2 <= '0; r_d1 <= '0; r_d2 <= '0;
            r_even <= '0; r_odd <= '0; r_warm <= '0;
        end else if (w_in_acc) begin
            r_a1   <= in_a;
            r_a2   <= r_a1;
            r_d1   <= in_d;
            r_d2   <= r_d1;
            r_even <= w_even;
            r_odd  <= w_odd;
            if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
        end
    end

    assign w_sel = (r_state == S_ODD) ? r_odd : r_even;

`ifdef IDAUB6_SAT_EN
    localparam logic signed [ACC_W-1:0] W_MAX =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] W_MIN =
        {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    logic signed [ACC_W-1:0] w_shr;

    assign w_shr = w_sel >>> SHIFT;

    always_comb begin
        out_x = w_shr[DATA_WIDTH-1:0];
        if (w_shr > W_MAX)      out_x = W_MAX[DATA_WIDTH-1:0];
        else if (w_shr < W_MIN) out_x = W_MIN[DATA_WIDTH-1:0];
    end
`else
    assign out_x = DATA_WIDTH'(w_sel >>> SHIFT);
`endif

endmodule

// File: tb/tb_idaub6_synth.sv
// Directed self-checking bench for idaub6_synth (DATA_WIDTH=16, SHIFT=4).
module tb_idaub6_synth;

    typedef logic signed [15:0] s16_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    s16_t in_a = '0;
    s16_t in_d = '0;
    logic in_valid = 1'b0;
    logic in_ready;
    s16_t out_x;
    logic out_valid;
    logic out_ready = 1'b1;
    logic out_warm;

    int checks = 0;
    int failures = 0;

    s16_t p_a [8];
    s16_t p_d [8];
    s16_t got_x [8];
    logic got_w [8];
    int   got_cnt;
    int   got_cyc;

    idaub6_synth #(.DATA_WIDTH(16), .SHIFT(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_a(in_a), .in_d(in_d), .in_valid(in_valid), .in_ready(in_ready),
        .out_x(out_x), .out_valid(out_valid), .out_ready(out_ready),
        .out_warm(out_warm)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Streams n pairs from p_a/p_d, collecting every accepted output sample.
    task automatic run_pairs(input int n);
        int   sent;
        int   got;
        int   cyc;
        logic acc_prev;
        sent = 0; got = 0; cyc = 0; acc_prev = 1'b0;
        for (int i = 0; i < 8; i++) begin got_x[i] = '0; got_w[i] = 1'b0; end
        while (cyc < 40 && got < 2 * n) begin
            @(negedge clk);
            if (acc_prev) got_w[sent-1] = out_warm;
            acc_prev = 1'b0;
            in_valid = (sent < n);
            if (sent < n) begin in_a = p_a[sent]; in_d = p_d[sent]; end
            #1;
            if (out_valid && out_ready && got < 8) begin got_x[got] = out_x; got++; end
            if (in_valid && in_ready) begin sent++; acc_prev = 1'b1; end
            cyc++;
        end
        in_valid = 1'b0;
        got_cnt = got;
        got_cyc = cyc;
    endtask

    task automatic do_clear();
        @(negedge clk);
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic load_impulse(input s16_t a0, input s16_t d0);
        for (int i = 0; i < 8; i++) begin p_a[i] = '0; p_d[i] = '0; end
        p_a[0] = a0;
        p_d[0] = d0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_x !== 16'sd0) begin failures++; $display("FAIL rst_out_x got=%0d exp=0", out_x); end
        checks++; if (out_warm !== 1'b0) begin failures++; $display("FAIL rst_out_warm got=%b exp=0", out_warm); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_impulse();
        s16_t exp_x [6];
        logic exp_w [3];
        exp_x = '{16'sd5, 16'sd13, 16'sd7, -16'sd2, -16'sd1, 16'sd1};
        exp_w = '{1'b0, 1'b0, 1'b1};
        do_clear();
        load_impulse(16'sd16, 16'sd0);
        run_pairs(3);
        checks++; if (got_cnt !== 6) begin failures++; $display("FAIL impulse_count got=%0d exp=6", got_cnt); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_x[i] !== exp_x[i]) begin failures++; $display("FAIL impulse_x[%0d] got=%0d exp=%0d", i, got_x[i], exp_x[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin failures++; $display("FAIL impulse_warm[%0d] got=%b exp=%b", i, got_w[i], exp_w[i]); end
        end
    endtask

    task automatic test_back_to_back();
        // Three pairs, one output per cycle: first sample one cycle after accept, last after 7 cycles.
        do_clear();
        load_impulse(16'sd16, 16'sd0);
        run_pairs(3);
        checks++; if (got_cyc !== 7) begin failures++; $display("FAIL b2b_cycles got=%0d exp=7", got_cyc); end
    endtask

    task automatic test_detail();
        s16_t exp_x [6];
        exp_x = '{16'sd1, 16'sd1, -16'sd2, -16'sd7, 16'sd13, -16'sd5};
        do_clear();
        load_impulse(16'sd0, 16'sd16);
        run_pairs(3);
        checks++; if (got_cnt !== 6) begin failures++; $display("FAIL detail_count got=%0d exp=6", got_cnt); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_x[i] !== exp_x[i]) begin failures++; $display("FAIL detail_x[%0d] got=%0d exp=%0d", i, got_x[i], exp_x[i]); end
        end
    endtask

    task automatic test_const();
        s16_t exp_x [8];
        s16_t even_full;
`ifdef IDAUB6_SAT_EN
        even_full = 16'sd32767;
`else
        even_full = -16'sd18434;
`endif
        exp_x = '{16'sd12287, 16'sd28671, 16'sd22527, 16'sd10239,
                  even_full, 16'sd2047, even_full, 16'sd2047};
        do_clear();
        for (int i = 0; i < 8; i++) begin p_a[i] = 16'sd32767; p_d[i] = 16'sd32767; end
        run_pairs(4);
        checks++; if (got_cnt !== 8) begin failures++; $display("FAIL const_count got=%0d exp=8", got_cnt); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_x[i] !== exp_x[i]) begin failures++; $display("FAIL const_x[%0d] got=%0d exp=%0d", i, got_x[i], exp_x[i]); end
        end
    endtask

    task automatic test_backpressure();
        do_clear();
        @(negedge clk);
        in_valid = 1'b1; in_a = 16'sd16; in_d = 16'sd0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_first_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        in_a = 16'sd99; in_d = 16'sd99;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", i, out_valid); end
            checks++; if (out_x !== 16'sd5) begin failures++; $display("FAIL bp_hold_x[%0d] got=%0d exp=5", i, out_x); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_ready[%0d] got=%b exp=0", i, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++; if (out_x !== 16'sd5 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_resume_even got=%0d/%b exp=5/1", out_x, out_valid); end
        @(negedge clk);
        #1;
        checks++; if (out_x !== 16'sd13 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_resume_odd got=%0d/%b exp=13/1", out_x, out_valid); end
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
        load_impulse(16'sd0, 16'sd0);
        run_pairs(1);
        checks++; if (got_cnt !== 2) begin failures++; $display("FAIL bp_next_count got=%0d exp=2", got_cnt); end
        checks++; if (got_x[0] !== 16'sd7) begin failures++; $display("FAIL bp_next_even got=%0d exp=7", got_x[0]); end
        checks++; if (got_x[1] !== -16'sd2) begin failures++; $display("FAIL bp_next_odd got=%0d exp=-2", got_x[1]); end
    endtask

    task automatic test_reset_mid();
        s16_t exp_x [6];
        exp_x = '{16'sd5, 16'sd13, 16'sd7, -16'sd2, -16'sd1, 16'sd1};
        do_clear();
        @(negedge clk);
        in_valid = 1'b1; in_a = 16'sd16; in_d = 16'sd0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        checks++; if (out_x !== 16'sd13 || out_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%0d/%b exp=13/1", out_x, out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
        checks++; if (out_x !== 16'sd0) begin failures++; $display("FAIL rmid_x got=%0d exp=0", out_x); end
        checks++; if (out_warm !== 1'b0) begin failures++; $display("FAIL rmid_warm got=%b exp=0", out_warm); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", in_ready); end
        load_impulse(16'sd16, 16'sd0);
        run_pairs(3);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_x[i] !== exp_x[i]) begin failures++; $display("FAIL rmid_x[%0d] got=%0d exp=%0d", i, got_x[i], exp_x[i]); end
        end
    endtask

    task automatic test_clear();
        s16_t exp_x [6];
        exp_x = '{16'sd5, 16'sd13, 16'sd7, -16'sd2, -16'sd1, 16'sd1};
        do_clear();
        load_impulse(16'sd16, 16'sd0);
        run_pairs(3);
        @(negedge clk);
        in_valid = 1'b1; in_a = 16'sd16; in_d = 16'sd0;
        @(negedge clk);
        #1;
        checks++; if (out_warm !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL clr_pre got=%b/%b exp=1/1", out_warm, out_valid); end
        clear = 1'b1; in_a = 16'sd100; in_d = 16'sd100;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL clr_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_valid got=%b exp=0", out_valid); end
        checks++; if (out_warm !== 1'b0) begin failures++; $display("FAIL clr_warm got=%b exp=0", out_warm); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL clr_ready_after got=%b exp=1", in_ready); end
        load_impulse(16'sd16, 16'sd0);
        run_pairs(3);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_x[i] !== exp_x[i]) begin failures++; $display("FAIL clr_x[%0d] got=%0d exp=%0d", i, got_x[i], exp_x[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_back_to_back();
        test_detail();
        test_const();
        test_backpressure();
        test_reset_mid();
        test_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/idaub6_synth.md
IDAUB6_SYNTH -- requirements
Module: idaub6_synth

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of coefficient inputs and sample outputs, signed two's complement.
REQ-002 Parameter SHIFT, default 4: arithmetic right shift applied to each accumulated sum.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clear  input  1  synchronous history/FSM flush, active-high.
REQ-006 in_a  input  DATA_WIDTH  approximation coefficient a[n].
REQ-007 in_d  input  DATA_WIDTH  detail coefficient d[n].
REQ-008 in_valid / in_ready  input / output  1 each  coefficient-pair handshake; transfer when both are high.
REQ-009 out_x  output  DATA_WIDTH  reconstructed sample, even (x[2n]) then odd (x[2n+1]).
REQ-010 out_valid / out_ready  output / input  1 each  sample handshake; transfer when both are high.
REQ-011 out_warm  output  1  high once three pairs have been accepted since reset/clear (history fully populated).

Function
REQ-012 Lowpass integer taps h = {5, 13, 7, -2, -1, 1}; highpass g[k] = (-1)^k h[5-k] = {1, 1, -2, -7, 13, -5}; all products by shift-add only, no '*' operator.
REQ-013 Even: x[2n] = h0 a[n] + h2 a[n-1] + h4 a[n-2] + g0 d[n] + g2 d[n-1] + g4 d[n-2].
REQ-014 Odd: x[2n+1] = h1 a[n] + h3 a[n-1] + h5 a[n-2] + g1 d[n] + g3 d[n-1] + g5 d[n-2].
REQ-015 Accumulation at ACC_W = DATA_WIDTH+6 bits, lossless; result = acc >>> SHIFT (floor), then narrowed per REQ-024/025.
REQ-016 History a[n-1], a[n-2], d[n-1], d[n-2] shifts only on an accepted input pair; both sums are registered on that same edge.
REQ-017 FSM states: S_EMPTY, S_EVEN, S_ODD. S_EMPTY->S_EVEN on input accept; S_EVEN->S_ODD on output accept; S_ODD->S_EMPTY on output accept with no input accept; S_ODD->S_EVEN on simultaneous output and input accept.
REQ-018 in_ready = (state==S_EMPTY) | (state==S_ODD & out_ready); no combinational path from in_valid to out_valid.
REQ-019 out_valid high in S_EVEN and S_ODD; out_x = registered even sum in S_EVEN, odd sum in S_ODD; out_x stable while out_valid & !out_ready.
REQ-020 Latency: first sample valid the cycle after the input accept; sustained throughput one pair per two cycles with out_ready held high.
REQ-021 Warm-up counter saturates at 3; out_warm = (count==3); samples before warm use zero history.
REQ-022 clear: FSM->S_EMPTY, history and counter zeroed, any pending sample discarded; clear has priority over a simultaneous handshake, and an input presented in that cycle is not accepted (in_ready low).

Reset
REQ-023 rst_n low: state S_EMPTY, history, sum registers and warm-up counter zero; out_x=0, out_valid=0, out_warm=0, in_ready=1 after release; reset mid-sample discards it.

Configuration
REQ-024 With IDAUB6_SAT_EN defined: shifted result clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-025 Without IDAUB6_SAT_EN: shifted result truncated to low DATA_WIDTH bits (two's-complement wrap).

Structure
REQ-026 Package idaub6_pkg holds tap constants h/g, ACC_W offset (6), and state enum typedef.
REQ-027 Sub-module idaub6_mac: combinational 6-term shift-add dot product with tap selection parameter (even/odd), instantiated twice.

Verification
REQ-028 Impulse: pairs (a,d) = (16,0),(0,0),(0,0), out_ready=1 -> out_x = 5,13,7,-2,-1,1; out_warm rises after third accept.
REQ-029 Detail impulse: (0,16),(0,0),(0,0) -> out_x = 1,1,-2,-7,13,-5.
REQ-030 Constant a=d=32767, DATA_WIDTH=16, after warm -> even 32767 with IDAUB6_SAT_EN, -18434 without; odd 2047 both builds.
REQ-031 Backpressure: out_ready low 5 cycles in S_EVEN -> out_x/out_valid held, in_ready low, no pair consumed; resumes even then odd in order.
REQ-032 rst_n pulse low mid-sample (S_ODD) and separately clear asserted with in_valid high -> outputs per REQ-023/022, next impulse reproduces REQ-028 sequence from 5.
